// File: rtl/vec_mux_nt1_hs.sv
// vec_mux_nt1_hs: registered N-to-1 selector for packed signed vectors.
// Explicit-select or round-robin arbitration with valid/ready handshakes on
// every input channel and on the single registered output.
module vec_mux_nt1_hs #(
  parameter int unsigned DIMENSION = 16,
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned NUM_IN    = 4,
  parameter int unsigned SEL_W     = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en,
  input  logic                              mode,
  input  logic [SEL_W-1:0]                  sel,
  input  logic [NUM_IN*DIMENSION*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]                 in_valid,
  output logic [NUM_IN-1:0]                 in_ready,
  output logic [DIMENSION*WIDTH-1:0]        out_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [SEL_W-1:0]                  out_src,
  output logic                              sel_err
);

  localparam int unsigned VEC_W = DIMENSION * WIDTH;

  logic [VEC_W-1:0] w_ch [NUM_IN];

  logic             w_slot_free;
  logic             w_can_take;
  logic             w_sel_ok;
  logic             w_rr_found;
  logic [SEL_W-1:0] w_rr_idx;
  logic [SEL_W:0]   w_rr_cand;
  logic             w_grant_any;
  logic [SEL_W-1:0] w_grant_idx;
  logic             w_load;
  logic [SEL_W-1:0] w_rr_next;

  logic [VEC_W-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_src;
  logic             r_sel_err;
  logic [SEL_W-1:0] r_rr_ptr;

  // Split the flat input bus into per-channel vectors
  for (genvar g = 0; g < NUM_IN; g++) begin : g_ch
    assign w_ch[g] = in_data[g*VEC_W +: VEC_W];
  end

  // Output slot can accept a new vector when empty or being consumed this cycle
  assign w_slot_free = ~r_out_valid | out_ready;
  assign w_can_take  = en & w_slot_free;

  // Explicit select is legal only for an existing channel index
  always_comb begin
    w_sel_ok = 1'b0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) w_sel_ok = 1'b1;
    end
  end

  // Round-robin search: first valid channel at or after rr_ptr, wrapping
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_rr_cand  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      w_rr_cand = {1'b0, r_rr_ptr} + (SEL_W+1)'(i);
      if (w_rr_cand >= (SEL_W+1)'(NUM_IN)) w_rr_cand = w_rr_cand - (SEL_W+1)'(NUM_IN);
      if (!w_rr_found && in_valid[w_rr_cand[SEL_W-1:0]]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = w_rr_cand[SEL_W-1:0];
      end
    end
  end

  // Grant selection; mode and sel act combinationally in the same cycle
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    if (mode) begin
      w_grant_any = w_rr_found;
      w_grant_idx = w_rr_idx;
    end else if (w_sel_ok) begin
      w_grant_any = 1'b1;
      w_grant_idx = sel;
    end
  end

  // One-hot ready toward the granted channel only while the slot can take data
  always_comb begin
    in_ready = '0;
    if (w_can_take && w_grant_any) in_ready[w_grant_idx] = 1'b1;
  end

  assign w_load    = w_can_take & w_grant_any & in_valid[w_grant_idx];
  assign w_rr_next = (w_grant_idx == SEL_W'(NUM_IN - 1)) ? '0 : w_grant_idx + SEL_W'(1);

  // Output register, round-robin pointer and select-error pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
      r_sel_err   <= 1'b0;
      r_rr_ptr    <= '0;
    end else begin
      r_sel_err <= ~mode & en & ~w_sel_ok;
      if (w_load) begin
        r_out_data  <= w_ch[w_grant_idx];
        r_out_src   <= w_grant_idx;
        r_out_valid <= 1'b1;
        if (mode) r_rr_ptr <= w_rr_next;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;
  assign sel_err   = r_sel_err;

endmodule
